// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches, tracks outstanding requests,
// discards responses made stale by a redirect, and buffers instructions in a 2-entry queue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    logic [31:0] r_fpc;
    logic [31:0] r_rpc;
    logic [31:0] r_q_instr [2];
    logic [31:0] r_q_pc    [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic [1:0]  r_inflight;
    logic [1:0]  r_stale;

    logic        w_req_hs;
    logic        w_id_hs;
    logic        w_rsp_ok;
    logic        w_push;
    logic        w_tail;
    logic [1:0]  w_inflight_nxt;
    logic [31:0] w_redirect_pc;

    // Issue only while every outstanding request is guaranteed a queue slot on return.
    assign imem_req_valid = rst_n && (({1'b0, r_inflight} + {1'b0, r_count}) < 3'd2);
    assign imem_req_addr  = r_fpc;

    assign id_valid = (r_count != 2'd0);
    assign id_instr = r_q_instr[r_head];
    assign id_pc    = r_q_pc[r_head];

    assign w_req_hs       = imem_req_valid && imem_req_ready;
    assign w_id_hs        = id_valid && id_ready;
    assign w_rsp_ok       = imem_rsp_valid && (r_inflight != 2'd0);
    assign w_push         = w_rsp_ok && (r_stale == 2'd0) && !redirect_valid;
    assign w_tail         = r_head ^ r_count[0];
    assign w_inflight_nxt = r_inflight + {1'b0, w_req_hs} - {1'b0, w_rsp_ok};
    assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fpc      <= RESET_PC;
            r_rpc      <= RESET_PC;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 2'd0;
            r_stale    <= 2'd0;
            // NOTE: the two queue entries are reset because id_instr/id_pc must read 0 in reset.
            for (int i = 0; i < 2; i++) begin
                r_q_instr[i] <= 32'h0;
                r_q_pc[i]    <= 32'h0;
            end
        end else begin
            // NOTE: all state uses non-blocking assignments so later statements see pre-edge values.
            r_inflight <= w_inflight_nxt;
            if (w_req_hs) begin
                r_fpc <= r_fpc + 32'd4;
            end
            if (w_push) begin
                r_q_instr[w_tail] <= imem_rsp_data;
                r_q_pc[w_tail]    <= r_rpc;
                r_rpc             <= r_rpc + 32'd4;
            end
            if (redirect_valid) begin
                // Later assignments override the handshake advances above.
                r_fpc   <= w_redirect_pc;
                r_rpc   <= w_redirect_pc;
                r_count <= 2'd0;
                r_stale <= w_inflight_nxt;
            end else begin
                if (w_rsp_ok && (r_stale != 2'd0)) begin
                    r_stale <= r_stale - 2'd1;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_id_hs};
                if (w_id_hs) begin
                    r_head <= ~r_head;
                end
            end
        end
    end

endmodule
